alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 SHALL have parameter RING_SECONDS, default 60, number of second strobes RINGING lasts before auto-stop.
REQ-002 SHALL have parameter SNOOZE_MINUTES, default 5, snooze delay in minutes (1..59).
REQ-003 SHALL have port clock  in  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port seconds  in  6  current time seconds, 0..59, from the timekeeping counter.
REQ-006 SHALL have port minutes  in  6  current time minutes, 0..59.
REQ-007 SHALL have port hours  in  5  current time hours, 0..23.
REQ-008 SHALL have port arm  in  1  level switch; 1 enables the alarm.
REQ-009 SHALL have ports set_h, set_m, stop, snooze  in  1 each  level buttons, active-high, already synchronous to clock.
REQ-010 SHALL have port alarm_hours  out  5  stored alarm hour.
REQ-011 SHALL have port alarm_minutes  out  6  stored alarm minute.
REQ-012 SHALL have port state  out  2  current FSM state encoding.
REQ-013 SHALL have port ringing  out  1  high while the FSM is in RINGING.
REQ-014 SHALL have port buzzer  out  1  ringing AND seconds[0], registered.

Function
REQ-015 SHALL convert each button to a one-cycle pulse on its rising edge, valid the cycle after the input rises.
REQ-016 SHALL generate sec_strobe for one cycle whenever seconds differs from its value registered on the previous cycle.
REQ-017 SHALL increment alarm_hours on a set_h pulse, wrapping 23->0, and alarm_minutes on a set_m pulse, wrapping 59->0, only in IDLE or ARMED; ignored otherwise.
REQ-018 SHALL implement states IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-019 SHALL move to IDLE from any state in the cycle arm is sampled 0; highest priority.
REQ-020 SHALL move IDLE->ARMED when arm is sampled 1.
REQ-021 SHALL move ARMED->RINGING on sec_strobe with hours==alarm_hours, minutes==alarm_minutes, seconds==0; clear ring counter.
REQ-022 SHALL in RINGING count sec_strobes; at RING_SECONDS, move to ARMED.
REQ-023 SHALL move RINGING->ARMED and SNOOZE->ARMED on a stop pulse; stop outranks snooze and timeout in the same cycle.
REQ-024 SHALL move RINGING->SNOOZE on a snooze pulse, loading target = current hours:minutes + SNOOZE_MINUTES, minutes mod 60 with carry into hours mod 24 (23:58 + 5 -> 00:03).
REQ-025 SHALL move SNOOZE->RINGING on sec_strobe with time == target and seconds==0; ring counter cleared.
REQ-026 SHALL keep ringing, buzzer and state registered; ringing asserts the cycle after entering RINGING.

Reset
REQ-027 SHALL on reset_n low immediately force state=IDLE, alarm_hours=0, alarm_minutes=0, ringing=0, buzzer=0, ring counter=0, snooze target=0, edge and seconds history registers=0.
REQ-028 SHALL, if reset asserts mid-ring or mid-snooze, discard the ring/snooze and resume in IDLE after release.

Configuration
REQ-029 SHALL, with macro ALARM_SNOOZE_EN defined, implement SNOOZE state and snooze input per REQ-024/025.
REQ-030 SHALL, without ALARM_SNOOZE_EN, ignore snooze, never enter SNOOZE, and omit the target registers.

Structure
REQ-031 SHALL place the state enum, state encodings and the 59/23 wrap constants in package alarm_pkg.
REQ-032 SHALL implement button pulse generation in one sub-module edge_pulse, instantiated once per button.

Verification
REQ-033 Reset then arm=1, press set_h 7 times, set_m 30 times -> alarm 07:30, state=ARMED.
REQ-034 Drive time 07:29:59 -> 07:30:00 -> ringing=1 one cycle after the strobe; buzzer toggles with seconds[0]; auto-return to ARMED after 60 strobes.
REQ-035 Alarm 23:58 ringing, snooze pulse -> SNOOZE, target 00:03; time 00:03:00 -> RINGING again.
REQ-036 stop and snooze rise same cycle in RINGING -> ARMED; arm=0 with stop -> IDLE.
REQ-037 set_m pressed 60 times from 0 -> alarm_minutes back to 0; set_h while RINGING -> alarm unchanged.
REQ-038 reset_n pulsed low mid-RINGING -> all outputs 0 same cycle, state IDLE after release.

Source files
------------

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - state encoding, wrap constants and time helpers for alarm_ctrl
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam logic [5:0] MINUTE_MAX = 6'd59;
  localparam logic [4:0] HOUR_MAX   = 5'd23;

  function automatic logic [4:0] next_hour(input logic [4:0] h);
    return (h >= HOUR_MAX) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] next_minute(input logic [5:0] m);
    return (m >= MINUTE_MAX) ? 6'd0 : m + 6'd1;
  endfunction

  // Returns {hours, minutes} of h:m advanced by inc minutes (inc < 60).
  function automatic logic [10:0] add_minutes(input logic [4:0] h, input logic [5:0] m,
                                              input logic [5:0] inc);
    logic [6:0] sum;
    logic [4:0] nh;
    sum = {1'b0, m} + {1'b0, inc};
    nh  = h;
    if (sum > {1'b0, MINUTE_MAX}) begin
      sum = sum - 7'd60;
      nh  = next_hour(h);
    end
    return {nh, sum[5:0]};
  endfunction

endpackage

// File: rtl/edge_pulse.sv
// rtl/edge_pulse.sv - registered one-cycle pulse on the rising edge of a level input
module edge_pulse (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm clock controller: alarm set, match, ring timeout, snooze
// Snooze state and target registers exist only when ALARM_SNOOZE_EN is defined.
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [4:0] hours,
  input  logic       arm,
  input  logic       set_h,
  input  logic       set_m,
  input  logic       stop,
  input  logic       snooze,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic [1:0] state,
  output logic       ringing,
  output logic       buzzer
);

  localparam int CNT_W = $clog2(RING_SECONDS + 1);
  localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECONDS);

  alarm_state_t     state_q, state_next;
  logic [CNT_W-1:0] ring_cnt, cnt_next;
  logic [5:0]       seconds_q;
  logic             sec_strobe, at_alarm;
  logic             set_h_p, set_m_p, stop_p, snooze_p;

  edge_pulse u_set_h  (.clock(clock), .reset_n(reset_n), .level(set_h),  .pulse(set_h_p));
  edge_pulse u_set_m  (.clock(clock), .reset_n(reset_n), .level(set_m),  .pulse(set_m_p));
  edge_pulse u_stop   (.clock(clock), .reset_n(reset_n), .level(stop),   .pulse(stop_p));
  edge_pulse u_snooze (.clock(clock), .reset_n(reset_n), .level(snooze), .pulse(snooze_p));

  assign sec_strobe = (seconds != seconds_q);
  assign at_alarm   = (hours == alarm_hours) && (minutes == alarm_minutes) && (seconds == 6'd0);

`ifdef ALARM_SNOOZE_EN
  localparam logic [5:0] SNOOZE_INC = 6'(SNOOZE_MINUTES);
  logic [4:0]  tgt_h;
  logic [5:0]  tgt_m;
  logic [10:0] tgt_next;
  logic        at_target;
  assign at_target = (hours == tgt_h) && (minutes == tgt_m) && (seconds == 6'd0);
`else
  logic unused_snooze;
  assign unused_snooze = snooze_p;
`endif

  always_comb begin
    state_next = state_q;
    cnt_next   = ring_cnt;
`ifdef ALARM_SNOOZE_EN
    tgt_next   = {tgt_h, tgt_m};
`endif
    if (!arm) begin
      state_next = IDLE;
    end else begin
      case (state_q)
        IDLE: state_next = ARMED;
        ARMED: begin
          if (sec_strobe && at_alarm) begin
            state_next = RINGING;
            cnt_next   = '0;
          end
        end
        RINGING: begin
          if (stop_p) begin
            state_next = ARMED;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze_p) begin
            state_next = SNOOZE;
            tgt_next   = add_minutes(hours, minutes, SNOOZE_INC);
`endif
          end else if (sec_strobe) begin
            cnt_next = ring_cnt + CNT_W'(1);
            if (cnt_next == RING_LAST) state_next = ARMED;
          end
        end
        SNOOZE: begin
`ifdef ALARM_SNOOZE_EN
          if (stop_p) begin
            state_next = ARMED;
          end else if (sec_strobe && at_target) begin
            state_next = RINGING;
            cnt_next   = '0;
          end
`else
          state_next = IDLE;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      ring_cnt      <= '0;
      seconds_q     <= 6'd0;
      alarm_hours   <= 5'd0;
      alarm_minutes <= 6'd0;
      ringing       <= 1'b0;
      buzzer        <= 1'b0;
    end else begin
      state_q   <= state_next;
      ring_cnt  <= cnt_next;
      seconds_q <= seconds;
      ringing   <= (state_next == RINGING);
      buzzer    <= ringing & seconds[0];
      // Alarm time is only editable while nothing is ringing or pending.
      if (state_q == IDLE || state_q == ARMED) begin
        if (set_h_p) alarm_hours   <= next_hour(alarm_hours);
        if (set_m_p) alarm_minutes <= next_minute(alarm_minutes);
      end
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tgt_h <= 5'd0;
      tgt_m <= 6'd0;
    end else begin
      {tgt_h, tgt_m} <= tgt_next;
    end
  end
`endif

  assign state = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - randomized and directed bench for alarm_ctrl with a time-of-day model
module tb_alarm_ctrl;

  localparam int RING = 60;
  localparam int SNZ  = 5;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNOOZE_EN = 1'b1;
`else
  localparam bit SNOOZE_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       arm = 1'b0, set_h = 1'b0, set_m = 1'b0, stop = 1'b0, snooze = 1'b0;
  logic [5:0] seconds = 6'd0, minutes = 6'd0;
  logic [4:0] hours = 5'd0;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [1:0] state;
  logic       ringing, buzzer;

  alarm_ctrl #(.RING_SECONDS(RING), .SNOOZE_MINUTES(SNZ)) dut (
    .clock(clock), .reset_n(reset_n), .seconds(seconds), .minutes(minutes), .hours(hours),
    .arm(arm), .set_h(set_h), .set_m(set_m), .stop(stop), .snooze(snooze),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .state(state),
    .ringing(ringing), .buzzer(buzzer)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: mode 0 idle, 1 armed, 2 ringing, 3 snoozing; times as minutes of day.
  int       m_mode = 0, m_ah = 0, m_am = 0, m_cnt = 0, m_target = 0, sec_prev = 0;
  bit       m_ring = 0, m_buzz = 0;
  bit [3:0] hist1 = 0, hist2 = 0, presses;
  bit       strobe;
  int       tod, old_mode;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_ah = 0; m_am = 0; m_cnt = 0; m_target = 0; sec_prev = 0;
      m_ring = 0; m_buzz = 0; hist1 = 0; hist2 = 0;
    end else begin
      presses  = hist1 & ~hist2;
      strobe   = (int'(seconds) != sec_prev);
      tod      = int'(hours) * 60 + int'(minutes);
      old_mode = m_mode;
      if (!arm) m_mode = 0;
      else if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1) begin
        if (strobe && seconds == 0 && tod == m_ah * 60 + m_am) begin m_mode = 2; m_cnt = 0; end
      end else if (m_mode == 2) begin
        if (presses[2]) m_mode = 1;
        else if (SNOOZE_EN && presses[3]) begin m_mode = 3; m_target = (tod + SNZ) % 1440; end
        else if (strobe) begin
          m_cnt++;
          if (m_cnt == RING) m_mode = 1;
        end
      end else begin
        if (presses[2]) m_mode = 1;
        else if (strobe && seconds == 0 && tod == m_target) begin m_mode = 2; m_cnt = 0; end
      end
      if (old_mode <= 1) begin
        if (presses[0]) m_ah = (m_ah + 1) % 24;
        if (presses[1]) m_am = (m_am + 1) % 60;
      end
      m_buzz   = m_ring & seconds[0];
      m_ring   = (m_mode == 2);
      hist2    = hist1;
      hist1    = {snooze, stop, set_m, set_h};
      sec_prev = int'(seconds);
    end
  end

  always @(negedge clock) begin
    #1;
    check("state", int'(state), m_mode);
    check("ringing", int'(ringing), int'(m_ring));
    check("buzzer", int'(buzzer), int'(m_buzz));
    check("alarm_hours", int'(alarm_hours), m_ah);
    check("alarm_minutes", int'(alarm_minutes), m_am);
  end

  int tsec;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_time();
    hours   = 5'(tsec / 3600);
    minutes = 6'((tsec / 60) % 60);
    seconds = 6'(tsec % 60);
  endtask

  task automatic goto(input int h, input int m, input int s);
    tsec = h * 3600 + m * 60 + s;
    apply_time();
  endtask

  task automatic press(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      case (which)
        0: set_h = 1'b1;
        1: set_m = 1'b1;
        2: stop = 1'b1;
        default: snooze = 1'b1;
      endcase
      tick(1);
      set_h = 1'b0; set_m = 1'b0; stop = 1'b0; snooze = 1'b0;
      tick(1);
    end
  endtask

  task automatic ring_at_2358();
    goto(23, 57, 59); tick(2);
    goto(23, 58, 0);  tick(2);
  endtask

  initial begin
    goto(0, 0, 0);
    tick(3);
    check("reset_state", int'(state), 0);
    check("reset_alarm", int'({alarm_hours, alarm_minutes}), 0);
    check("reset_ring", int'({ringing, buzzer}), 0);
    reset_n = 1'b1;
    arm = 1'b1;
    tick(2);
    press(0, 7);
    press(1, 30);
    tick(2);
    check("set_hours_7", int'(alarm_hours), 7);
    check("set_minutes_30", int'(alarm_minutes), 30);
    check("armed", int'(state), 1);

    goto(7, 29, 59); tick(3);
    check("no_early_ring", int'(ringing), 0);
    goto(7, 30, 0); tick(1);
    check("ring_after_strobe", int'(ringing), 1);
    check("ring_state", int'(state), 2);
    for (int i = 1; i <= 60; i++) begin
      tsec++; apply_time(); tick(2);
      if (i == 1)  check("buzzer_odd_sec", int'(buzzer), 1);
      if (i == 2)  check("buzzer_even_sec", int'(buzzer), 0);
      if (i == 59) check("still_ringing_59", int'(state), 2);
      if (i == 60) check("timeout_armed", int'(state), 1);
    end

    press(0, 16);
    press(1, 28);
    check("alarm_2358", int'({alarm_hours, alarm_minutes}), (23 << 6) | 58);
    ring_at_2358();
    check("ring_2358", int'(state), 2);
    press(3, 1);
    check("snooze_state", int'(state), SNOOZE_EN ? 3 : 2);
    check("snooze_silent", int'(ringing), SNOOZE_EN ? 0 : 1);
    goto(0, 2, 59); tick(2);
    check("snooze_not_yet", int'(state), SNOOZE_EN ? 3 : 2);
    goto(0, 3, 0); tick(2);
    check("snooze_rering", int'(state), 2);

    stop = 1'b1; snooze = 1'b1; tick(1);
    stop = 1'b0; snooze = 1'b0; tick(1);
    check("stop_beats_snooze", int'(state), 1);
    ring_at_2358();
    check("ring_again", int'(state), 2);
    arm = 1'b0; stop = 1'b1; tick(2);
    check("disarm_idle", int'(state), 0);
    stop = 1'b0; arm = 1'b1; tick(2);
    check("rearm", int'(state), 1);

    ring_at_2358();
    goto(23, 58, 1); tick(2);
    check("buzz_before_reset", int'(buzzer), 1);
    reset_n = 1'b0; #1;
    check("rst_ringing", int'(ringing), 0);
    check("rst_buzzer", int'(buzzer), 0);
    check("rst_state", int'(state), 0);
    check("rst_alarm", int'({alarm_hours, alarm_minutes}), 0);
    tick(2);
    reset_n = 1'b1; #1;
    check("idle_after_release", int'(state), 0);
    tick(2);
    check("armed_after_release", int'(state), 1);

    press(1, 59);
    check("minutes_59", int'(alarm_minutes), 59);
    press(1, 1);
    check("minutes_wrap", int'(alarm_minutes), 0);
    goto(23, 59, 59); tick(2);
    goto(0, 0, 0); tick(2);
    check("ring_midnight", int'(state), 2);
    press(0, 1);
    check("set_h_ignored", int'(alarm_hours), 0);
    press(2, 1);
    check("stop_armed", int'(state), 1);

    tsec = $urandom_range(0, 86399);
    apply_time();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      case ($urandom_range(0, 99))
        0, 1: tsec = (((m_ah * 60 + m_am) * 60) - int'($urandom_range(1, 2)) + 86400) % 86400;
        2, 3: tsec = ((m_target * 60) - 1 + 86400) % 86400;
        default: if ($urandom_range(0, 3) == 0) tsec = (tsec + 1) % 86400;
      endcase
      apply_time();
      if ($urandom_range(0, 15) == 0) set_h = ~set_h;
      if ($urandom_range(0, 15) == 0) set_m = ~set_m;
      if ($urandom_range(0, 19) == 0) stop = ~stop;
      if ($urandom_range(0, 9) == 0)  snooze = ~snooze;
      if (arm) begin
        if ($urandom_range(0, 299) == 0) arm = 1'b0;
      end else if ($urandom_range(0, 3) == 0) arm = 1'b1;
    end
    tick(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
